fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks a combinational instruction ROM, hands instructions to
// decode through a valid/ready register stage, follows absolute jumps, stops on
// a halt opcode and accepts execute-stage redirects.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         COUNT_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [7:0]         o_inst_address,
  input  logic [9:0]         i_inst_in,
  output logic [9:0]         o_inst_out,
  output logic               o_inst_valid,
  input  logic               i_inst_ready,
  output logic [7:0]         o_pc,
  input  logic               i_redirect,
  input  logic [7:0]         i_redirect_target,
  output logic               o_halted,
  output logic [COUNT_W-1:0] o_issue_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_HALTPEND = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JUMP = 4'b1001;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [1:0]         r_state;
  logic [7:0]         r_fetch_pc;
  logic [9:0]         r_inst_out;
  logic [7:0]         r_pc;
  logic               r_inst_valid;
  logic [COUNT_W-1:0] r_issue_count;

  logic       w_transfer;
  logic       w_load_en;
  logic       w_is_jump;
  logic       w_is_halt;
  logic       w_active;
  logic       w_restart;
  logic [7:0] w_next_pc;

  // Handshake and next-address decode for the word currently on the ROM bus.
  always_comb begin
    w_transfer = r_inst_valid && i_inst_ready;
    w_load_en  = !r_inst_valid || i_inst_ready;
    w_is_jump  = (i_inst_in[9:6] == OP_JUMP);
    w_is_halt  = (i_inst_in[9:6] == OP_HALT);
    w_active   = (r_state == S_FETCH) || (r_state == S_HALTPEND);
    w_restart  = ((r_state == S_IDLE) || (r_state == S_HALT)) && i_start;
    // 8-bit add wraps 255 -> 0 naturally.
    w_next_pc  = w_is_jump ? {2'b00, i_inst_in[5:0]} : r_fetch_pc + 8'd1;
  end

  // Control FSM plus the fetch address and the decode-facing instruction register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_inst_out   <= 10'b0;
      r_pc         <= 8'd0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            r_state      <= S_FETCH;
            r_fetch_pc   <= RESET_PC;
            r_inst_valid <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_redirect) begin
            // Squash whatever is held, even if decode takes it this cycle.
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= i_redirect_target;
          end else if (w_load_en) begin
            r_inst_out   <= i_inst_in;
            r_pc         <= r_fetch_pc;
            r_inst_valid <= 1'b1;
            r_fetch_pc   <= w_next_pc;
            if (w_is_halt) begin
              r_state <= S_HALTPEND;
            end
          end
        end
        S_HALTPEND: begin
          // The halt word is held until decode accepts it; no more ROM captures.
          if (i_redirect) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= i_redirect_target;
            r_state      <= S_FETCH;
          end else if (w_transfer) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_HALT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of accepted instructions since the last start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_issue_count <= '0;
    end else if (w_restart) begin
      r_issue_count <= '0;
    end else if (w_active && w_transfer && (r_issue_count != COUNT_MAX)) begin
      r_issue_count <= r_issue_count + COUNT_W'(1);
    end
  end

  assign o_inst_address = r_fetch_pc;
  assign o_inst_out     = r_inst_out;
  assign o_inst_valid   = r_inst_valid;
  assign o_pc           = r_pc;
  assign o_halted       = (r_state == S_HALT);
  assign o_issue_count  = r_issue_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed program scenarios plus random ROM
// contents and random decode back-pressure, checked against a program-walk model.
module tb_fetch_sequencer;

  localparam int CW = 3;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    inst_address;
  logic [9:0]    inst_in;
  logic [9:0]    inst_out;
  logic          inst_valid;
  logic          inst_ready;
  logic [7:0]    pc;
  logic          redirect;
  logic [7:0]    redirect_target;
  logic          halted;
  logic [CW-1:0] issue_count;

  logic [9:0] rom [256];
  assign inst_in = rom[inst_address];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [9:0] obs_inst[$];

  fetch_sequencer #(.RESET_PC(8'd0), .COUNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_inst_address(inst_address), .i_inst_in(inst_in),
    .o_inst_out(inst_out), .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_pc(pc), .i_redirect(redirect), .i_redirect_target(redirect_target),
    .o_halted(halted), .o_issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the sequence of addresses a program issues from a given start,
  // following jumps, ending with (and including) a halt word.
  task automatic model_walk(input logic [7:0] start_pc, input int cap);
    logic [7:0] a;
    a = start_pc;
    exp_q.delete();
    for (int i = 0; i < cap; i++) begin
      exp_q.push_back(a);
      if (rom[a][9:6] == 4'b0000) break;
      if (rom[a][9:6] == 4'b1001) a = {2'b00, rom[a][5:0]};
      else a = a + 8'd1;
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) rom[i] = 10'b0;
    rom[0]   = 10'b0100101001;
    rom[1]   = 10'b1001000101;
    rom[5]   = 10'b0000100101;
    rom[255] = 10'b0100000000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, sample handshake, return just after the rising edge.
  task automatic cycle(input logic st, input logic rdy, input logic rd, input logic [7:0] tgt,
                       output logic xfer, output logic [7:0] pc_s, output logic [9:0] ins_s);
    @(negedge clk);
    start = st; inst_ready = rdy; redirect = rd; redirect_target = tgt;
    #1;
    xfer  = inst_valid && rdy;
    pc_s  = pc;
    ins_s = inst_out;
    @(posedge clk);
    #1;
    start = 1'b0; redirect = 1'b0;
  endtask

  // Run with no redirects until halted or max_xfers transfers seen; records every transfer.
  task automatic collect(input int max_xfers, input int budget, input bit rnd, output bit timed_out);
    logic x; logic [7:0] p; logic [9:0] ins; logic r;
    obs_q.delete(); obs_inst.delete();
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(1'b0, r, 1'b0, 8'd0, x, p, ins);
      if (x) begin
        obs_q.push_back(p);
        obs_inst.push_back(ins);
        $display("xfer pc=%0d inst=%b count=%0d", p, ins, issue_count);
      end
      if (halted || obs_q.size() >= max_xfers) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_target = 8'd0;
    load_program();
    #3;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_checks++; if (inst_out !== 10'b0) begin n_fail++; $display("FAIL reset_inst got %b want 0", inst_out); end
    n_checks++; if (pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (issue_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", issue_count); end
    n_checks++; if (inst_address !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", inst_address); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic x; logic [7:0] p; logic [9:0] ins;
      cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_fetch got valid=%b want 0", inst_valid); end
    end
  endtask

  task automatic test_basic_program();
    logic x; logic [7:0] p; logic [9:0] ins; bit to;
    load_program();
    model_walk(8'd0, 64);
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL start_latency0 got valid=%b want 0", inst_valid); end
    cycle(1'b0, 1'b0, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (inst_valid !== 1'b1 || pc !== 8'd0) begin n_fail++; $display("FAIL start_latency1 got valid=%b pc=%0d want 1/0", inst_valid, pc); end
    collect(64, 20, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got no halt want halt"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_pc[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    // Ready was held high, so one transfer per cycle then halt one cycle after the last.
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted got %b want 1", halted); end
    n_checks++; if (issue_count !== CW'(3)) begin n_fail++; $display("FAIL basic_count got %0d want 3", issue_count); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %b want 0", inst_valid); end
  endtask

  task automatic test_stall();
    logic x; logic [7:0] p; logic [9:0] ins; bit to;
    model_walk(8'd0, 64);
    cycle(1'b1, 1'b0, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (halted !== 1'b0 || issue_count !== '0) begin n_fail++; $display("FAIL restart got halted=%b count=%0d want 0/0", halted, issue_count); end
    cycle(1'b0, 1'b0, 1'b0, 8'd0, x, p, ins);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'd0, x, p, ins);
      n_checks++;
      if (inst_valid !== 1'b1 || pc !== 8'd0 || inst_out !== rom[0]) begin
        n_fail++; $display("FAIL stall_hold got valid=%b pc=%0d inst=%b want 1/0/%b", inst_valid, pc, inst_out, rom[0]);
      end
    end
    collect(64, 20, 1'b0, to);
    n_checks++; if (to || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_pc[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (issue_count !== CW'(3)) begin n_fail++; $display("FAIL stall_count got %0d want 3", issue_count); end
  endtask

  task automatic test_redirect();
    logic x; logic [7:0] p; logic [9:0] ins; bit to;
    do_reset(); load_program();
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
    cycle(1'b0, 1'b1, 1'b1, 8'd2, x, p, ins);
    n_checks++; if (x !== 1'b1 || p !== 8'd0) begin n_fail++; $display("FAIL redir_xfer got xfer=%b pc=%0d want 1/0", x, p); end
    n_checks++; if (issue_count !== CW'(1)) begin n_fail++; $display("FAIL redir_count got %0d want 1", issue_count); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash got valid=%b want 0", inst_valid); end
    cycle(1'b0, 1'b0, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (inst_valid !== 1'b1 || pc !== 8'd2) begin n_fail++; $display("FAIL redir_latency got valid=%b pc=%0d want 1/2", inst_valid, pc); end
    model_walk(8'd2, 64);
    collect(64, 20, 1'b0, to);
    n_checks++; if (to || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL redir_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL redir_pc[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (issue_count !== CW'(1 + exp_q.size())) begin n_fail++; $display("FAIL redir_total got %0d want %0d", issue_count, 1 + exp_q.size()); end
  endtask

  task automatic test_redirect_haltpend();
    logic x; logic [7:0] p; logic [9:0] ins; bit to; bit found;
    do_reset(); load_program();
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
      if (inst_valid && pc == 8'd5) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL hp_reach got no pc5 want pc5 held"); end
    cycle(1'b0, 1'b1, 1'b1, 8'd0, x, p, ins);
    n_checks++; if (halted !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL hp_cancel got halted=%b valid=%b want 0/0", halted, inst_valid); end
    n_checks++; if (issue_count !== CW'(3)) begin n_fail++; $display("FAIL hp_count got %0d want 3", issue_count); end
    cycle(1'b0, 1'b0, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (halted !== 1'b0 || inst_valid !== 1'b1 || pc !== 8'd0) begin n_fail++; $display("FAIL hp_reissue got halted=%b valid=%b pc=%0d want 0/1/0", halted, inst_valid, pc); end
    model_walk(8'd0, 64);
    collect(64, 20, 1'b0, to);
    n_checks++; if (to || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL hp_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hp_pc[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (issue_count !== CW'(6)) begin n_fail++; $display("FAIL hp_total got %0d want 6", issue_count); end
  endtask

  task automatic test_wrap();
    logic x; logic [7:0] p; logic [9:0] ins; bit to;
    do_reset(); load_program();
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    cycle(1'b0, 1'b1, 1'b1, 8'd255, x, p, ins);
    model_walk(8'd255, 64);
    collect(64, 20, 1'b0, to);
    n_checks++; if (to || obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic x; logic [7:0] p; logic [9:0] ins; bit to;
    do_reset(); load_program();
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_out !== 10'b0 || pc !== 8'd0 || halted !== 1'b0 ||
        issue_count !== '0 || inst_address !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got valid=%b inst=%b pc=%0d halted=%b count=%0d addr=%0d want 0s",
               inst_valid, inst_out, pc, halted, issue_count, inst_address);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0, x, p, ins);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got valid=%b want 0", inst_valid); end
    cycle(1'b1, 1'b1, 1'b0, 8'd0, x, p, ins);
    model_walk(8'd0, 64);
    collect(64, 20, 1'b0, to);
    n_checks++; if (to || obs_q.size() !== exp_q.size() || obs_q[0] !== 8'd0) begin n_fail++; $display("FAIL post_reset_seq got len=%0d want %0d", obs_q.size(), exp_q.size()); end
    n_checks++; if (issue_count !== CW'(3)) begin n_fail++; $display("FAIL post_reset_count got %0d want 3", issue_count); end
  endtask

  task automatic test_random(input int iter);
    logic x; logic [7:0] p; logic [9:0] ins; bit to; int n;
    for (int i = 0; i < 256; i++) rom[i] = 10'($urandom);
    rom[0][9:6] = 4'b0100;
    do_reset();
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'd0, x, p, ins);
    model_walk(8'd0, 40);
    collect(40, 600, 1'b1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout got %0d xfers want %0d", iter, obs_q.size(), exp_q.size()); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len got %0d want %0d", iter, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_inst[i] !== rom[exp_q[i]]) begin
        n_fail++; $display("FAIL rand%0d_xfer[%0d] got pc=%0d inst=%b want pc=%0d inst=%b", iter, i, obs_q[i], obs_inst[i], exp_q[i], rom[exp_q[i]]);
      end
    end
    n = obs_q.size();
    n_checks++;
    if (issue_count !== ((n > int'(CMAX)) ? CMAX : CW'(n))) begin
      n_fail++; $display("FAIL rand%0d_count got %0d want %0d", iter, issue_count, (n > int'(CMAX)) ? int'(CMAX) : n);
    end
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_stall();
    test_redirect();
    test_redirect_haltpend();
    test_wrap();
    test_reset_midstream();
    for (int k = 0; k < 4; k++) test_random(k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
